// File: rtl/ff_bank_arbiter.sv
// ff_bank_arbiter
// ---------------
// Round-robin arbiter that lets NREQ requesters take turns updating one shared
// WIDTH-bit state register. Each granted request applies a single bitwise
// flip-flop style update: D load, T toggle, SR set/reset or JK. A requester that
// holds its lock bit may issue back-to-back updates. The number of updates in
// one locked grant is limited to HOLD_MAX, after which the grant rotates.
//
// Ports
//   clk    rising-edge clock
//   rst    asynchronous, active-low reset
//   req    per-requester request, held with stable op/a/b until its ack
//   lock   per-requester lock hint, sampled at the edge that ends a grant cycle
//   op     2 bits per requester: 00 D, 01 T, 10 SR, 11 JK
//   a      WIDTH bits per requester: D data / T mask / S / J
//   b      WIDTH bits per requester: R / K (ignored for D and T)
//   gnt    registered one-hot grant
//   ack    registered one-cycle completion pulse to the owner
//   q      shared state register
//   err    pulses with ack when an SR op had bits with both S and R set
//   busy   high whenever a grant is outstanding
//   owner  index of the current or most recent grantee
module ff_bank_arbiter #(
    parameter int NREQ     = 4,
    parameter int WIDTH    = 8,
    parameter int HOLD_MAX = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ-1:0]         lock,
    input  logic [2*NREQ-1:0]       op,
    input  logic [WIDTH*NREQ-1:0]   a,
    input  logic [WIDTH*NREQ-1:0]   b,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         ack,
    output logic [WIDTH-1:0]        q,
    output logic                    err,
    output logic                    busy,
    output logic [$clog2(NREQ)-1:0] owner
);

    localparam int IW = $clog2(NREQ);
    // hold_cnt only ever reaches HOLD_MAX-1 before the grant is released
    localparam int HW = (HOLD_MAX < 2) ? 1 : $clog2(HOLD_MAX);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t            state, state_nx;
    logic [NREQ-1:0]   gnt_nx;
    logic [NREQ-1:0]   ack_nx;
    logic [WIDTH-1:0]  q_nx;
    logic              err_nx;
    logic [IW-1:0]     owner_nx;
    logic [IW-1:0]     rr_ptr, rr_nx;
    logic [HW-1:0]     hold_cnt, hold_nx;

    logic              found;
    logic [IW-1:0]     winner;
    logic [IW-1:0]     next_ptr;
    logic [1:0]        own_op;
    logic [WIDTH-1:0]  own_a;
    logic [WIDTH-1:0]  own_b;
    logic [WIDTH-1:0]  conflict;
    logic [WIDTH-1:0]  op_q;
    logic              sr_err;

    assign busy = |gnt;

    // Operands of whoever owns the bank right now
    assign own_op   = op[2*owner +: 2];
    assign own_a    = a[WIDTH*owner +: WIDTH];
    assign own_b    = b[WIDTH*owner +: WIDTH];
    assign conflict = own_a & own_b;

    // Pointer position just past the owner, wrapping at NREQ
    assign next_ptr = (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;

    // Round-robin pick: first active request at or after the pointer
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (int'(rr_ptr) + k) % NREQ;
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = IW'(idx);
            end
        end
    end

    // Bitwise update of the bank for the owner's op. In SR, bits with both S
    // and R asserted keep their old value and raise the error pulse.
    always_comb begin
        op_q   = q;
        sr_err = 1'b0;
        case (own_op)
            2'b00: op_q = own_a;
            2'b01: op_q = q ^ own_a;
            2'b10: begin
                op_q   = (((q | own_a) & ~own_b) & ~conflict) | (q & conflict);
                sr_err = |conflict;
            end
            default: op_q = (own_a & ~q) | (~own_b & q);
        endcase
    end

    // Next-state logic. A grant stays in place only while the owner keeps its
    // lock and request asserted and the hold budget is not used up. A dropped
    // request during a grant cycle abandons the op without an ack.
    always_comb begin
        state_nx = state;
        gnt_nx   = gnt;
        ack_nx   = '0;
        err_nx   = 1'b0;
        q_nx     = q;
        owner_nx = owner;
        rr_nx    = rr_ptr;
        hold_nx  = hold_cnt;
        case (state)
            IDLE: begin
                if (found) begin
                    gnt_nx   = NREQ'(1) << winner;
                    owner_nx = winner;
                    hold_nx  = '0;
                    state_nx = GRANT;
                end
            end
            GRANT: begin
                if (!req[owner]) begin
                    gnt_nx   = '0;
                    rr_nx    = next_ptr;
                    state_nx = IDLE;
                end else begin
                    q_nx   = op_q;
                    ack_nx = gnt;
                    err_nx = sr_err;
                    if (lock[owner] && (int'(hold_cnt) + 1 < HOLD_MAX)) begin
                        hold_nx = hold_cnt + 1'b1;
                    end else begin
                        gnt_nx   = '0;
                        rr_nx    = next_ptr;
                        state_nx = IDLE;
                    end
                end
            end
            default: begin
                gnt_nx   = '0;
                state_nx = IDLE;
            end
        endcase
    end

    // State register; the asynchronous clear discards any op in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            gnt      <= '0;
            ack      <= '0;
            err      <= 1'b0;
            q        <= '0;
            owner    <= '0;
            rr_ptr   <= '0;
            hold_cnt <= '0;
        end else begin
            state    <= state_nx;
            gnt      <= gnt_nx;
            ack      <= ack_nx;
            err      <= err_nx;
            q        <= q_nx;
            owner    <= owner_nx;
            rr_ptr   <= rr_nx;
            hold_cnt <= hold_nx;
        end
    end

endmodule
